rand_seq_buffer: RTL and testbench
==================================

RAND_SEQ_BUFFER -- requirements
Module: rand_seq_buffer

Interface
REQ-001 Parameter DATA_W, default 5, width of random samples and sequence entries.
REQ-002 Parameter DEPTH, default 16, maximum number of stored sequence entries.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rnd_data  input  DATA_W  free-running pseudo-random value from the upstream Fibonacci LFSR, which changes every clock.
REQ-006 start  input  1  one-cycle request to capture a new sequence and then play it.
REQ-007 replay  input  1  one-cycle request to play the stored sequence again without refilling it.
REQ-008 seq_len  input  DATA_W  requested sequence length; values above DEPTH are clamped to DEPTH.
REQ-009 range_max  input  DATA_W  inclusive upper bound on accepted samples.
REQ-010 out_data  output  DATA_W  current playback entry.
REQ-011 out_valid  output  1  out_data holds a valid entry.
REQ-012 out_ready  input  1  downstream accepts out_data when both out_valid and out_ready are high.
REQ-013 busy  output  1  high in the FILL and PLAY states.
REQ-014 done  output  1  one-cycle pulse after the last entry is accepted.

Function
REQ-015 The block SHALL implement the states IDLE, FILL, PLAY and DONE.
REQ-016 From IDLE, start=1 SHALL cause a transition to FILL on the next edge and clear the write index.
REQ-017 From IDLE, replay=1 with start=0 and a non-empty stored sequence SHALL cause a transition to PLAY with the read index at 0.
REQ-018 If start and replay are both high in IDLE, start SHALL take priority.
REQ-019 start and replay SHALL be ignored outside IDLE.
REQ-020 In FILL, rnd_data SHALL be sampled every cycle and accepted only if rnd_data <= range_max and rnd_data differs from the previously accepted entry; the first entry has no previous-entry check.
REQ-021 Each accepted sample SHALL be written at the write index, and the write index SHALL then increment.
REQ-022 FILL SHALL transition to PLAY on the edge that writes entry L-1, where L is the clamped seq_len.
REQ-023 If seq_len=0, start SHALL go IDLE->DONE directly, with no writes, no out_valid and a stored length of 0.
REQ-024 In PLAY, out_valid SHALL be 1 and out_data SHALL equal the entry at the read index.
REQ-025 In PLAY, out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 On each handshake the read index SHALL increment.
REQ-027 The handshake on entry L-1 SHALL transition the block to DONE.
REQ-028 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-029 Minimum latency from start to first out_valid SHALL be L+1 cycles when every sample is accepted.
REQ-030 out_valid SHALL be 0 in IDLE, FILL and DONE.
REQ-031 Indices SHALL be wide enough that DEPTH does not wrap; clamped L=DEPTH SHALL fill every entry.
REQ-032 range_max=2^DATA_W-1 SHALL accept every sample, subject only to the repeat check.
REQ-033 seq_len and range_max SHALL be registered at start; later changes SHALL NOT affect the run in progress.
REQ-034 The stored length SHALL persist across runs, so replay uses the most recent fill.

Reset
REQ-035 Asserting rst_n=0 at any time, including mid-FILL or mid-PLAY, SHALL immediately force: state IDLE, out_valid=0, busy=0, done=0, out_data=0, indices=0, stored length=0.
REQ-036 Sequence memory contents need not be cleared, but a replay before any completed fill SHALL be ignored because the stored length is 0.
REQ-037 Release of rst_n SHALL take effect on the next rising edge of clk.

Structure
REQ-038 The state encoding, DATA_W and DEPTH defaults SHALL reside in the shared package rand_seq_pkg.
REQ-039 Storage SHALL be a sub-module rand_seq_mem: a DEPTH x DATA_W register file with one synchronous write port and one asynchronous read port.
REQ-040 The FSM, sample filter and indices SHALL reside in rand_seq_buffer.

Verification
REQ-041 Stimulus: seq_len=4, range_max=31, rnd_data 3,7,7,9,12 on successive FILL cycles, out_ready=1 -> required response: out_data 3,7,9,12; done pulse once; 7 rejected once.
REQ-042 Stimulus: range_max=5, rnd_data 20,2,31,5,1, seq_len=3 -> required response: stored 2,5,1; out_valid rises 6 cycles after start.
REQ-043 Stimulus: out_ready held low 5 cycles in PLAY -> required response: out_data and out_valid held constant; completes normally when out_ready=1.
REQ-044 Stimulus: seq_len=20 -> required response: exactly 16 entries played. Stimulus: seq_len=0 -> required response: done one cycle after start, out_valid never high.
REQ-045 Stimulus: replay after a completed run -> required response: identical sequence output. Stimulus: replay after reset -> required response: ignored.
REQ-046 Stimulus: rst_n pulsed low mid-PLAY -> required response: outputs cleared asynchronously; a subsequent start completes a full run.

Source files
------------

// File: rtl/rand_seq_pkg.sv
// Shared defaults and state encoding for the random-sequence capture/playback buffer.
package rand_seq_pkg;

   localparam int DATA_W_DEF = 5;
   localparam int DEPTH_DEF  = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_PLAY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/rand_seq_mem.sv
// Sequence storage: DEPTH x DATA_W register file, synchronous write, asynchronous read.
module rand_seq_mem #(
   parameter int DATA_W = 5,
   parameter int DEPTH  = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // contents are deliberately not reset; the stored length gates their use
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rand_seq_buffer.sv
// Captures a filtered run of LFSR samples into a small memory and plays it back
// over a valid/ready handshake; replay re-plays the most recent fill.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start (new fill) or replay (stored sequence)
// FILL    | sampling rnd_data, writing accepted samples
// PLAY    | presenting entries on out_data with out_valid high
// DONE    | one-cycle done pulse, then back to IDLE
module rand_seq_buffer
   import rand_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] rnd_data,
   input  logic              start,
   input  logic              replay,
   input  logic [DATA_W-1:0] seq_len,
   input  logic [DATA_W-1:0] range_max,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   // one extra bit so a length of exactly DEPTH is representable
   localparam int IDX_W = $clog2(DEPTH + 1);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]        state;
   logic [IDX_W-1:0]  wr_idx, rd_idx, len_q, len_clamped, last_idx;
   logic [DATA_W-1:0] range_q, prev_q, rd_data;
   logic              accept;

   always_comb begin
      len_clamped = IDX_W'(seq_len);
      if (32'(seq_len) > DEPTH) len_clamped = IDX_W'(DEPTH);
   end

   assign last_idx = len_q - IDX_W'(1);
   assign accept   = (state == ST_FILL) && (rnd_data <= range_q) &&
                     ((wr_idx == '0) || (rnd_data != prev_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         wr_idx  <= '0;
         rd_idx  <= '0;
         len_q   <= '0;
         range_q <= '0;
         prev_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  range_q <= range_max;
                  len_q   <= len_clamped;
                  wr_idx  <= '0;
                  state   <= (len_clamped == '0) ? ST_DONE : ST_FILL;
               end else if (replay && (len_q != '0)) begin
                  rd_idx <= '0;
                  state  <= ST_PLAY;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  prev_q <= rnd_data;
                  wr_idx <= wr_idx + IDX_W'(1);
                  if (wr_idx == last_idx) begin
                     rd_idx <= '0;
                     state  <= ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (out_ready) begin
                  if (rd_idx == last_idx) state <= ST_DONE;
                  else                    rd_idx <= rd_idx + IDX_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   rand_seq_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_idx[AW-1:0]),
      .wdata (rnd_data),
      .raddr (rd_idx[AW-1:0]),
      .rdata (rd_data)
   );

   // outputs decode straight from state so an async reset clears them at once
   assign out_valid = (state == ST_PLAY);
   assign out_data  = out_valid ? rd_data : '0;
   assign busy      = (state == ST_FILL) || (state == ST_PLAY);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_rand_seq_buffer.sv
// Directed bench for rand_seq_buffer: hand-computed fill/playback sequences.
module tb_rand_seq_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rnd_data, seq_len, range_max, out_data;
   logic       start, replay, out_valid, out_ready, busy, done;

   int errors = 0;
   int checks = 0;
   int smp[$];
   int expv[$];
   int first_valid;

   rand_seq_buffer #(.DATA_W(5), .DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rnd_data  (rnd_data),
      .start     (start),
      .replay    (replay),
      .seq_len   (seq_len),
      .range_max (range_max),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input int len, input int rmax);
      seq_len   = 5'(len);
      range_max = 5'(rmax);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   // feeds smp[] on successive FILL cycles; PLAY must begin right after the last one
   task automatic fill_run(input string tag);
      first_valid = -1;
      for (int i = 0; i < smp.size(); i++) begin
         rnd_data = 5'(smp[i]);
         step();
         if (out_valid && first_valid < 0) first_valid = i + 2;
         if (i == smp.size() - 1) check({tag, "_valid_end"}, int'(out_valid), 1);
         else                     check({tag, "_valid_fill"}, int'(out_valid), 0);
      end
   endtask

   task automatic play_run(input string tag);
      out_ready = 1'b1;
      foreach (expv[i]) begin
         check({tag, "_valid"}, int'(out_valid), 1);
         check({tag, "_data"}, int'(out_data), expv[i]);
         step();
      end
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_valid_done"}, int'(out_valid), 0);
      check({tag, "_busy_done"}, int'(busy), 0);
      step();
      check({tag, "_done_clr"}, int'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0; rnd_data = '0; start = 1'b0; replay = 1'b0;
      seq_len = '0; range_max = '0; out_ready = 1'b0;
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_data", int'(out_data), 0);
      step();
      rst_n = 1'b1;
      step();

      // replay with nothing stored must be ignored
      replay = 1'b1; step(); replay = 1'b0;
      check("replay_empty_busy", int'(busy), 0);
      check("replay_empty_valid", int'(out_valid), 0);

      // repeat rejection: 3,7,7,9,12 -> 3,7,9,12
      kick(4, 31);
      check("t1_busy_fill", int'(busy), 1);
      smp = '{3, 7, 7, 9, 12};
      fill_run("t1");
      expv = '{3, 7, 9, 12};
      play_run("t1");

      // range filter and latency; inputs changed mid-run must not matter
      kick(3, 5);
      seq_len = 5'd9; range_max = 5'd31;
      smp = '{20, 2, 31, 5, 1};
      fill_run("t2");
      check("t2_latency", first_valid, 6);
      expv = '{2, 5, 1};
      play_run("t2");

      // replay with 5-cycle stall; start/replay ignored while playing
      out_ready = 1'b0;
      replay = 1'b1; step(); replay = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start = 1'b1; replay = 1'b1; end
         check("t3_stall_valid", int'(out_valid), 1);
         check("t3_stall_data", int'(out_data), 2);
         step();
         start = 1'b0; replay = 1'b0;
      end
      play_run("t3");

      // clamp: seq_len=20 plays exactly 16 entries
      kick(20, 31);
      smp.delete(); expv.delete();
      for (int i = 0; i < 16; i++) begin
         smp.push_back(i + 1);
         expv.push_back(i + 1);
      end
      fill_run("t4");
      play_run("t4");

      // zero length: straight to DONE, stored length becomes 0
      kick(0, 31);
      check("t5_done", int'(done), 1);
      check("t5_valid", int'(out_valid), 0);
      check("t5_busy", int'(busy), 0);
      step();
      check("t5_done_clr", int'(done), 0);
      replay = 1'b1; step(); replay = 1'b0;
      check("t5_replay_ign", int'(out_valid), 0);

      // async reset mid-PLAY
      kick(3, 31);
      smp = '{4, 8, 4};
      fill_run("t6");
      out_ready = 1'b0;
      check("t6_data_pre", int'(out_data), 4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", int'(out_valid), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_data", int'(out_data), 0);
      step();
      rst_n = 1'b1;
      step();
      replay = 1'b1; step(); replay = 1'b0;
      check("t6_replay_ign", int'(busy), 0);
      kick(3, 31);
      smp = '{6, 6, 0, 9};
      fill_run("t7");
      expv = '{6, 0, 9};
      play_run("t7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
